// File: rtl/fir_pkg.sv
// Shared constants, types and coefficient table for the 16-tap serial FIR front end.
// Imported by the MAC controller, its coefficient ROM and the bench.
package fir_pkg;

  localparam int unsigned TAPS   = 16;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned COEF_W = 11;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned TAP_W  = $clog2(TAPS);
  localparam int unsigned ACC_W  = PROD_W + $clog2(TAPS);

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic        [TAP_W-1:0]  tap_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN,
    ST_CAPT
  } state_t;

  // One beat towards the downstream accumulator.
  typedef struct packed {
    prod_t prod;
    logic  valid;
    logic  bypass;
    logic  capture;
  } mac_beat_t;

  // h[k]; the last tap carries the most negative coefficient so the
  // (-2048)*(-1024) corner is reachable with real data.
  localparam coef_t COEF [TAPS] = '{
    coef_t'(3),    coef_t'(-7),   coef_t'(15),   coef_t'(-31),
    coef_t'(62),   coef_t'(-120), coef_t'(250),  coef_t'(1023),
    coef_t'(1023), coef_t'(250),  coef_t'(-120), coef_t'(62),
    coef_t'(-31),  coef_t'(15),   coef_t'(-7),   coef_t'(-1024)
  };

  function automatic logic is_last_tap(input tap_t k);
    return k == tap_t'(TAPS - 1);
  endfunction

endpackage

// File: rtl/serial_fir_mac_ctrl_if.sv
// Sample input handshake plus product/strobe stream of the serial FIR front end.
// master = sample source / accumulator side, slave = MAC controller.
interface serial_fir_mac_ctrl_if;
  import fir_pkg::*;

  sample_t din_i;
  logic    din_valid_i;
  logic    din_ready_o;
  prod_t   prod_o;
  logic    prod_valid_o;
  logic    bypass_o;
  logic    capture_o;
  logic    busy_o;

  modport master (
    output din_i,
    output din_valid_i,
    input  din_ready_o,
    input  prod_o,
    input  prod_valid_o,
    input  bypass_o,
    input  capture_o,
    input  busy_o
  );

  modport slave (
    input  din_i,
    input  din_valid_i,
    output din_ready_o,
    output prod_o,
    output prod_valid_o,
    output bypass_o,
    output capture_o,
    output busy_o
  );

endinterface

// File: rtl/fir_coef_rom.sv
// Combinational coefficient lookup h[k] from the shared table.
module fir_coef_rom
  import fir_pkg::*;
(
  input  tap_t  tap,
  output coef_t coef_c
);

  always_comb coef_c = COEF[tap];

endmodule

// File: rtl/serial_fir_mac_ctrl.sv
// Serial FIR front end: 16-deep delay line, tap walker, shared signed multiplier
// and the bypass/capture strobes for a 1-cycle-latency downstream accumulator.
module serial_fir_mac_ctrl
  import fir_pkg::*;
(
  input logic                 clk_i,
  input logic                 rst_n_i,
  serial_fir_mac_ctrl_if.slave bus
);

  state_t    state;
  state_t    state_n;
  tap_t      tap;
  tap_t      tap_n;
  mac_beat_t beat;
  mac_beat_t beat_n;
  logic      ready;
  logic      ready_n;
  logic      busy;
  logic      busy_n;
  logic      accept_c;

  sample_t   dly [TAPS];
  sample_t   x_sel_c;
  coef_t     coef_c;
  prod_t     prod_c;

  fir_coef_rom u_coef_rom (
    .tap    (tap),
    .coef_c (coef_c)
  );

  // Full-precision signed product; both operands sign-extended to PROD_W.
  assign x_sel_c = dly[tap];
  assign prod_c  = prod_t'(x_sel_c) * prod_t'(coef_c);

  // Next state, tap and output beat; outputs are registered from these.
  always_comb begin
    state_n        = state;
    tap_n          = tap;
    accept_c       = 1'b0;
    beat_n         = beat;
    beat_n.valid   = 1'b0;
    beat_n.bypass  = 1'b0;
    beat_n.capture = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.din_valid_i) begin
          accept_c = 1'b1;
          tap_n    = '0;
          state_n  = ST_MAC;
        end
      end
      ST_MAC: begin
        beat_n.prod   = prod_c;
        beat_n.valid  = 1'b1;
        beat_n.bypass = (tap == '0);
        if (is_last_tap(tap)) begin
          state_n = ST_DRAIN;
        end else begin
          tap_n = tap + tap_t'(1);
        end
      end
      ST_DRAIN: begin
        // The last product is in the accumulator by the end of this cycle.
        beat_n.capture = 1'b1;
        state_n        = ST_CAPT;
      end
      ST_CAPT: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    ready_n = (state_n == ST_IDLE);
    busy_n  = !ready_n;
  end

  // Control and output registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
      tap   <= '0;
      beat  <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      tap   <= tap_n;
      beat  <= beat_n;
      ready <= ready_n;
      busy  <= busy_n;
    end
  end

  // Delay line: x[0] is the newest sample; frozen outside an accept.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        dly[i] <= '0;
      end
    end else if (accept_c) begin
      dly[0] <= bus.din_i;
      for (int unsigned i = 1; i < TAPS; i++) begin
        dly[i] <= dly[i-1];
      end
    end
  end

  assign bus.din_ready_o  = ready;
  assign bus.busy_o       = busy;
  assign bus.prod_o       = beat.prod;
  assign bus.prod_valid_o = beat.valid;
  assign bus.bypass_o     = beat.bypass;
  assign bus.capture_o    = beat.capture;

endmodule
